// File: rtl/rect_fill_engine.sv
// ---------------------------------------------------------------------------
// rect_fill_engine
//
// Fills a clipped rectangle of the FB_DIM x FB_DIM framebuffer with one solid
// colour. It drives the video memory port directly, one aligned word per
// cycle, and packs pixels for the selected depth (24/16/8/4 bpp). A 4bpp word
// whose edge byte is only half covered is read first, then written back with
// the covered nibbles replaced (read-modify-write).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             1-cycle command strobe, only sampled while idle
//   x0, y0            top-left pixel of the rectangle
//   w, h              width / height in pixels (0..128), clipped at the edge
//   color             RGB888 fill colour
//   depth             0=24bpp 1=16bpp 2=8bpp 3=4bpp
//   base              framebuffer base word address
//   busy, done        command in progress / 1-cycle completion pulse
//   mem_en, mem_we    memory access enable, byte write enables (0 = read)
//   mem_addr          {1'b0, word address}; bit 15 is always 0
//   mem_write         write data
//   mem_read          read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module rect_fill_engine #(
  parameter int FB_DIM = 128,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [6:0]        x0,
  input  logic [6:0]        y0,
  input  logic [7:0]        w,
  input  logic [7:0]        h,
  input  logic [23:0]       color,
  input  logic [1:0]        depth,
  input  logic [ADDR_W-1:0] base,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [15:0]       mem_addr,
  output logic [31:0]       mem_write,
  input  logic [31:0]       mem_read
);

  typedef enum logic [2:0] {IDLE, ROW, WR, RD, MRG, DONE} state_t;

  // Last covered coordinate, clipped to the framebuffer edge (len >= 1).
  function automatic logic [6:0] clip_end(input logic [6:0] first, input logic [7:0] len);
    logic [8:0] sum;
    sum = {2'b00, first} + {1'b0, len};
    if (sum >= 9'(FB_DIM)) return 7'(FB_DIM - 1);
    else                   return 7'(sum - 9'd1);
  endfunction

  // Pixel value replicated into every slot of a 32-bit word.
  function automatic logic [31:0] pack_color(input logic [23:0] c, input logic [1:0] d);
    logic [15:0] p16;
    logic [7:0]  p8;
    p16 = {c[23:19], c[15:10], c[7:3]};
    p8  = {c[23:21], c[15:13], c[7:6]};
    case (d)
      2'd0:    return {8'h00, c};
      2'd1:    return {2{p16}};
      2'd2:    return {4{p8}};
      default: return {8{c[23:20]}};
    endcase
  endfunction

  // Slots of word `word` whose x lies in [xl, xh]. Words never straddle a
  // row because FB_DIM is a multiple of the largest slot count (8).
  function automatic logic [7:0] slot_mask(input logic [13:0] word, input logic [1:0] s,
                                           input logic [6:0] xl, input logic [6:0] xh);
    logic [7:0] m;
    logic [6:0] px;
    logic [2:0] k3;
    // NOTE: m gets a value before any conditional update, so no path leaves it unassigned and no latch is inferred.
    m = '0;
    for (int k = 0; k < 8; k++) begin
      k3 = 3'(k);
      px = 7'(word << s) + 7'(k);
      if (((k3 >> s) == 3'd0) && (px >= xl) && (px <= xh)) m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [3:0] byte_we(input logic [7:0] m, input logic [1:0] s);
    case (s)
      2'd0:    return 4'b1111;
      2'd1:    return {m[1], m[1], m[0], m[0]};
      2'd2:    return m[3:0];
      default: return {m[7] & m[6], m[5] & m[4], m[3] & m[2], m[1] & m[0]};
    endcase
  endfunction

  function automatic logic [31:0] nib_expand(input logic [7:0] m);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[4*k +: 4] = {4{m[k]}};
    return r;
  endfunction

  state_t            state;
  logic [6:0]        x0_q, xe_q, ye_q, y_q;
  logic [1:0]        s_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [31:0]       p_q, wdata_q;
  logic [13:0]       wp, lw;        // current / last word index of the row
  logic [7:0]        nib_q;         // slot mask of the word on the bus

  logic [13:0] row_first, row_last, next_word;
  logic [7:0]  next_mask;
  logic [3:0]  next_we;
  logic        next_partial, issue, row_end;

  assign row_first = {y_q, x0_q} >> s_q;
  assign row_last  = {y_q, xe_q} >> s_q;
  assign row_end   = (wp == lw);
  assign next_word = (state == ROW) ? row_first : wp + 14'd1;
  assign next_mask = slot_mask(next_word, s_q, x0_q, xe_q);
  assign next_we   = byte_we(next_mask, s_q);
  // A 4bpp byte with exactly one covered nibble cannot be written with byte enables.
  assign next_partial = (s_q == 2'd3) &&
                        (|{next_mask[7] ^ next_mask[6], next_mask[5] ^ next_mask[4],
                           next_mask[3] ^ next_mask[2], next_mask[1] ^ next_mask[0]});
  assign issue = (state == ROW) || (((state == WR) || (state == MRG)) && !row_end);

  assign mem_addr = {{(16 - ADDR_W){1'b0}}, addr_q};
  // Read data only arrives in the MRG cycle, so the merge is combinational
  // from mem_read; this keeps a read-modify-write at one extra cycle.
  assign mem_write = (state == MRG)
                   ? ((wdata_q & nib_expand(nib_q)) | (mem_read & ~nib_expand(nib_q)))
                   : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: command registers are reset as well, so an aborted fill leaves no stale state behind.
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
      x0_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      y_q     <= '0;
      s_q     <= '0;
      base_q  <= '0;
      p_q     <= '0;
      wp      <= '0;
      lw      <= '0;
      nib_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register sees pre-edge values regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          mem_en <= 1'b0;
          mem_we <= 4'h0;
          if (start) begin
            x0_q   <= x0;
            y_q    <= y0;
            xe_q   <= clip_end(x0, w);
            ye_q   <= clip_end(y0, h);
            s_q    <= depth;
            base_q <= base;
            p_q    <= pack_color(color, depth);
            if (w == 8'd0 || h == 8'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= ROW;
            end
          end
        end
        ROW: lw <= row_last;
        WR, MRG: begin
          if (row_end) begin
            mem_en <= 1'b0;
            mem_we <= 4'h0;
            if (y_q < ye_q) begin
              y_q   <= y_q + 7'd1;
              state <= ROW;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RD: begin
          mem_we <= 4'hF;
          state  <= MRG;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Put the next word of the row on the bus.
      if (issue) begin
        wp      <= next_word;
        mem_en  <= 1'b1;
        addr_q  <= base_q + ADDR_W'(next_word);
        wdata_q <= p_q;
        nib_q   <= next_mask;
        if (next_partial) begin
          mem_we <= 4'h0;
          state  <= RD;
        end else begin
          mem_we <= next_we;
          state  <= WR;
        end
      end
    end
  end

endmodule
